// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the hazard sequencer (master) and the 5-stage pipeline datapath (slave).
// Holds the hazard-detection inputs, the stage enables and flushes, and the sequencer status.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       mem_pcsrc;
  logic       mem_access;
  logic       dmem_ready;
  logic       dmem_req;
  logic       pc_we;
  logic       ifid_we;
  logic       idex_we;
  logic       exmem_we;
  logic       memwb_we;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       mem_timeout;
  logic [1:0] state;

  modport master (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_pcsrc, mem_access, dmem_ready,
    output dmem_req, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, mem_timeout, state
  );

  modport slave (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
           mem_pcsrc, mem_access, dmem_ready,
    input  dmem_req, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, exmem_flush, mem_timeout, state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use stalls, branch flushes, data-memory wait and timeout.
// Optional macro PIPE_PERF_CNT_EN adds stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.master bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;
  logic             load_use;

  assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                    ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path can infer a latch.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    advance          = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.pc_we        = 1'b0;
    bus.ifid_we      = 1'b0;
    bus.idex_we      = 1'b0;
    bus.exmem_we     = 1'b0;
    bus.memwb_we     = 1'b0;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.exmem_flush  = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.mem_access) begin
          bus.dmem_req = 1'b1;
          if (bus.dmem_ready) begin
            advance = 1'b1;
          end else begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        bus.dmem_req = 1'b1;
        if (bus.dmem_ready) begin
          advance = 1'b1;
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;  // ERROR: everything frozen until reset
    endcase

    // A taken branch wins over load-use; mem_pcsrc is only honoured when the pipeline moves.
    if (advance) begin
      bus.pc_we    = 1'b1;
      bus.ifid_we  = 1'b1;
      bus.idex_we  = 1'b1;
      bus.exmem_we = 1'b1;
      bus.memwb_we = 1'b1;
      if (bus.mem_pcsrc) begin
        bus.ifid_flush  = 1'b1;
        bus.idex_flush  = 1'b1;
        bus.exmem_flush = 1'b1;
      end else if (load_use) begin
        bus.pc_we      = 1'b0;
        bus.ifid_we    = 1'b0;
        bus.idex_flush = 1'b1;
      end
    end

    if (rst) begin
      bus.dmem_req    = 1'b0;
      bus.pc_we       = 1'b0;
      bus.ifid_we     = 1'b0;
      bus.idex_we     = 1'b0;
      bus.exmem_we    = 1'b0;
      bus.memwb_we    = 1'b0;
      bus.ifid_flush  = 1'b1;
      bus.idex_flush  = 1'b1;
      bus.exmem_flush = 1'b1;
    end
  end

  assign bus.mem_timeout = (state_q == ERROR);
  assign bus.state       = state_q;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!bus.pc_we)      stall_cycles <= stall_cycles + 32'd1;
      if (bus.exmem_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table plus hand sequences for wait, timeout and reset.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  pipe_hazard_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipe_hazard_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Expected-output packing: {dmem_req, pc,ifid,idex,exmem,memwb we, ifid,idex,exmem flush, mem_timeout, state[1:0]}
  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt, memread;
    logic [4:0] ex_rt;
    logic       pcsrc, access, ready;
    logic [11:0] exp;
  } vec_t;

  localparam logic [11:0] NORMAL = 12'b0_11111_000_0_00;
  localparam logic [11:0] STALL  = 12'b0_00111_010_0_00;
  localparam logic [11:0] BRANCH = 12'b0_11111_111_0_00;
  localparam logic [11:0] FREEZE = 12'b1_00000_000_0_00;
  localparam logic [11:0] WAIT1  = 12'b1_00000_000_0_01;
  localparam logic [11:0] ERR    = 12'b0_00000_000_1_10;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t tbl[13];
  logic [11:0] o;

  function automatic logic [11:0] outs();
    return {bus.dmem_req, bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we,
            bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.mem_timeout, bus.state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic mr, input logic [4:0] ert, input logic pc, input logic acc,
                       input logic rdy);
    rst            = r;
    bus.id_rs      = rs;
    bus.id_rt      = rt;
    bus.id_uses_rt = ur;
    bus.ex_memread = mr;
    bus.ex_rt      = ert;
    bus.mem_pcsrc  = pc;
    bus.mem_access = acc;
    bus.dmem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{"reset",          1, 0, 0, 0, 0, 0, 0, 0, 0, 12'b0_00000_111_0_00};
    tbl[1]  = '{"idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, NORMAL};
    tbl[2]  = '{"loaduse_rs",     0, 8, 2, 0, 1, 8, 0, 0, 0, STALL};
    tbl[3]  = '{"after_stall",    0, 8, 2, 0, 0, 8, 0, 0, 0, NORMAL};
    tbl[4]  = '{"zero_reg",       0, 0, 0, 1, 1, 0, 0, 0, 0, NORMAL};
    tbl[5]  = '{"loaduse_rt",     0, 3, 9, 1, 1, 9, 0, 0, 0, STALL};
    tbl[6]  = '{"rt_not_used",    0, 3, 9, 0, 1, 9, 0, 0, 0, NORMAL};
    tbl[7]  = '{"no_memread",     0, 9, 9, 1, 0, 9, 0, 0, 0, NORMAL};
    tbl[8]  = '{"branch_over_lu", 0, 8, 2, 0, 1, 8, 1, 0, 0, BRANCH};
    tbl[9]  = '{"branch_only",    0, 4, 5, 1, 0, 7, 1, 0, 0, BRANCH};
    tbl[10] = '{"zero_wait",      0, 4, 5, 1, 0, 7, 0, 1, 1, 12'b1_11111_000_0_00};
    tbl[11] = '{"zero_wait_lu",   0, 6, 5, 0, 1, 6, 0, 1, 1, 12'b1_00111_010_0_00};
    tbl[12] = '{"zero_wait_br",   0, 6, 5, 0, 1, 6, 1, 1, 1, 12'b1_11111_111_0_00};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].memread,
            tbl[i].ex_rt, tbl[i].pcsrc, tbl[i].access, tbl[i].ready);
      #2;
      check(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
      tick();
    end

    // Memory wait: ready low for three cycles then high; a pending branch is ignored while frozen.
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    #2; check("wait_enter", 32'(outs()), 32'(FREEZE));
    tick();
    for (int k = 0; k < 2; k++) begin
      #2; check($sformatf("wait_hold%0d", k), 32'(outs()), 32'(WAIT1));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    #2; check("wait_done", 32'(outs()), 32'(12'b1_11111_000_0_01));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2; check("wait_back_run", 32'(outs()), 32'(NORMAL));
    tick();

    // Timeout: 1 RUN freeze cycle + 15 MEM_WAIT cycles, then ERROR.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 16; k++) begin
      #2; check($sformatf("to_frozen%0d", k), 32'(outs()), 32'(k == 0 ? FREEZE : WAIT1));
      tick();
    end
    #2; check("to_error", 32'(outs()), 32'(ERR));
    drive(0, 8, 0, 0, 1, 8, 1, 1, 1);
    tick();
    #2; check("error_sticky", 32'(outs()), 32'(ERR));
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2; o = outs(); check("error_rst_ctl", 32'(o[11:3]), 32'(9'b0_00000_111));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2; check("error_cleared", 32'(outs()), 32'(NORMAL));
    tick();

    // Reset in the middle of a wait.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    #2; check("midwait_rst_out", 32'(outs()), 32'(12'b0_00000_111_0_01));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2; check("midwait_released", 32'(outs()), 32'(NORMAL));
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall_zero", stall_cycles, 32'd0);
    check("perf_flush_zero", flush_events, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 8, 0, 0, 1, 8, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("perf_stall_one", stall_cycles, 32'd1);
    check("perf_flush_one", flush_events, 32'd1);
`endif
    tick();

    // Timeout again after reset mid-wait: the counter must restart so ERROR arrives after exactly 16 cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 16; k++) tick();
    #2; o = outs(); check("to2_state", 32'(o[1:0]), 32'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end
endmodule
